// File: rtl/beat_sequencer.sv
// Key-press pattern recorder/player sitting between the keyboard decoder and the
// tone rate divider; passes live keys through, logs (note, duration) events, replays them.
module beat_sequencer #(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 500000,
    parameter int DUR_W    = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [6:0]               key_ascii,
    input  logic                     record_en,
    input  logic                     play_start,
    input  logic                     stop,
    output logic [6:0]               tone_ascii,
    output logic                     is_record,
    output logic                     playing,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       tone_q, tone_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             done_q, done_d;
    logic             is_record_q, playing_q;
    logic [TW-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [6:0]       cur_note_q, cur_note_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             rec_en_q;

    logic [6:0]       note_mem_q [DEPTH];
    logic [DUR_W-1:0] dur_mem_q  [DEPTH];

    logic             tick_s;
    logic             rec_rise_s;
    logic             rec_fall_s;
    logic             wr_en_s;
    logic [6:0]       wr_note_s;
    logic [DUR_W-1:0] wr_dur_s;
    logic [AW-1:0]    idx_nxt_s;
    logic             last_s;

    assign tick_s     = (tick_q == TW'(TICK_DIV - 1));
    assign rec_rise_s = record_en & ~rec_en_q;
    assign rec_fall_s = ~record_en & rec_en_q;
    assign idx_nxt_s  = idx_q + AW'(1);
    assign last_s     = (({1'b0, idx_q} + CW'(1)) == count_q);

    // Next-state, buffer write request and output values for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        tone_d     = tone_q;
        count_d    = count_q;
        done_d     = 1'b0;
        tick_d     = tick_s ? {TW{1'b0}} : (tick_q + TW'(1));
        dur_d      = dur_q;
        cur_note_d = cur_note_q;
        idx_d      = idx_q;
        wr_en_s    = 1'b0;
        wr_note_s  = cur_note_q;
        wr_dur_s   = dur_q;

        case (state_q)
            S_IDLE: begin
                tone_d = key_ascii;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (rec_rise_s) begin
                    state_d    = S_RECORD;
                    count_d    = {CW{1'b0}};
                    cur_note_d = key_ascii;
                    dur_d      = {DUR_W{1'b0}};
                    tick_d     = {TW{1'b0}};
                end else if (play_start) begin
                    if (count_q != {CW{1'b0}}) begin
                        state_d = S_PLAY;
                        idx_d   = {AW{1'b0}};
                        dur_d   = {DUR_W{1'b0}};
                        tick_d  = {TW{1'b0}};
                        tone_d  = note_mem_q[0];
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RECORD: begin
                tone_d = key_ascii;
                if (stop || rec_fall_s) begin
                    // Flush the partially timed note only if it lasted at least one tick.
                    if ((dur_q != {DUR_W{1'b0}}) && (count_q != CW'(DEPTH))) begin
                        wr_en_s = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    state_d = S_IDLE;
                    tick_d  = {TW{1'b0}};
                end else if ((key_ascii != cur_note_q) || (dur_q == DUR_MAX)) begin
                    wr_en_s    = 1'b1;
                    wr_dur_s   = (dur_q == {DUR_W{1'b0}}) ? DUR_W'(1) : dur_q;
                    count_d    = count_q + CW'(1);
                    cur_note_d = key_ascii;
                    dur_d      = {DUR_W{1'b0}};
                    tick_d     = {TW{1'b0}};
                    if ((count_q + CW'(1)) == CW'(DEPTH)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RECORD;
                    end
                end else if (tick_s) begin
                    dur_d = dur_q + DUR_W'(1);
                end else begin
                    dur_d = dur_q;
                end
            end

            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                    tone_d  = key_ascii;
                    tick_d  = {TW{1'b0}};
                end else if (tick_s) begin
                    if ((dur_q + DUR_W'(1)) >= dur_mem_q[idx_q]) begin
                        dur_d = {DUR_W{1'b0}};
                        if (last_s) begin
                            tone_d  = 7'd0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d  = idx_nxt_s;
                            tone_d = note_mem_q[idx_nxt_s];
                        end
                    end else begin
                        dur_d = dur_q + DUR_W'(1);
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end

            default: begin
                state_d = S_IDLE;
                tone_d  = 7'd0;
            end
        endcase

        full_d = (count_d == CW'(DEPTH));
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            tone_q      <= 7'd0;
            count_q     <= {CW{1'b0}};
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            is_record_q <= 1'b0;
            playing_q   <= 1'b0;
            tick_q      <= {TW{1'b0}};
            dur_q       <= {DUR_W{1'b0}};
            cur_note_q  <= 7'd0;
            idx_q       <= {AW{1'b0}};
            rec_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tone_q      <= tone_d;
            count_q     <= count_d;
            full_q      <= full_d;
            done_q      <= done_d;
            is_record_q <= (state_d == S_RECORD);
            playing_q   <= (state_d == S_PLAY);
            tick_q      <= tick_d;
            dur_q       <= dur_d;
            cur_note_q  <= cur_note_d;
            idx_q       <= idx_d;
            rec_en_q    <= record_en;
        end
    end

    // Event buffer; contents are not reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            note_mem_q[count_q[AW-1:0]] <= wr_note_s;
            dur_mem_q[count_q[AW-1:0]]  <= wr_dur_s;
        end
    end

    assign tone_ascii = tone_q;
    assign is_record  = is_record_q;
    assign playing    = playing_q;
    assign count      = count_q;
    assign full       = full_q;
    assign done       = done_q;

endmodule
